// File: rtl/matrix_codec_pkg.sv
// matrix_codec_pkg: shared sizes, FSM states and inverse column-parity kernels for the matrix codec.
// Kernels invert T = 1 + X + X^-1*Z in GF(2)[X,Z]/(X^5-1, Z^W-1), evaluated at elaboration time.
package matrix_codec_pkg;

    localparam int SLICE_BITS = 25;
    localparam int ROWS       = 5;
    localparam int COLS       = 5;
    localparam int MAX_LANE_W = 64;

    typedef enum logic [1:0] {
        LOAD,
        SOLVE,
        CHECK,
        EMIT
    } state_t;

    // Row x holds the Z coefficients of X^x; only the low LANE_W bits of each row are meaningful.
    typedef logic [COLS-1:0][MAX_LANE_W-1:0] kernel_t;

    function automatic logic [COLS-1:0] col_parity(input logic [SLICE_BITS-1:0] slice);
        logic [COLS-1:0] par;
        par = '0;
        for (int x = 0; x < COLS; x++) begin
            for (int y = 0; y < ROWS; y++) begin
                par[x] = par[x] ^ slice[x + COLS * y];
            end
        end
        return par;
    endfunction

    // Multiplies a ring element by X^dx * Z^dz (dx, dz non-negative).
    function automatic kernel_t ring_shift(input kernel_t a, input int dx, input int dz, input int w);
        kernel_t r;
        r = '0;
        for (int x = 0; x < COLS; x++) begin
            for (int z = 0; z < w; z++) begin
                r[(x + dx) % COLS][(z + dz) % w] = a[x][z];
            end
        end
        return r;
    endfunction

    function automatic logic [COLS-1:0] poly_mul(input logic [COLS-1:0] a, input logic [COLS-1:0] b);
        logic [COLS-1:0] prod;
        prod = '0;
        for (int i = 0; i < COLS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                prod[(i + j) % COLS] = prod[(i + j) % COLS] ^ (a[i] & b[j]);
            end
        end
        return prod;
    endfunction

    // T^(w-1) is the product of the squared factors T^(2^k); T^w has no Z term left and is a unit
    // of GF(2)[X]/(X^5-1), whose unit group has exponent 15, so its inverse is (T^w)^14.
    function automatic kernel_t gen_inv_kernel(input int w);
        kernel_t         acc;
        kernel_t         res;
        logic [COLS-1:0] u;
        logic [COLS-1:0] uinv;
        int              sx;
        acc       = '0;
        acc[0][0] = 1'b1;
        for (int k = 1; k < w; k = k * 2) begin
            sx  = k % COLS;
            acc = acc ^ ring_shift(acc, sx, 0, w) ^ ring_shift(acc, COLS - sx, k, w);
        end
        sx = w % COLS;
        u  = '0;
        u[0]        = 1'b1;
        u[sx]       = u[sx] ^ 1'b1;
        u[COLS - sx] = u[COLS - sx] ^ 1'b1;
        uinv = 5'b00001;
        for (int n = 0; n < 14; n++) begin
            uinv = poly_mul(uinv, u);
        end
        res = '0;
        for (int j = 0; j < COLS; j++) begin
            if (uinv[j]) begin
                res = res ^ ring_shift(acc, j, 0, w);
            end
        end
        return res;
    endfunction

    localparam kernel_t INV_Q_W1  = gen_inv_kernel(1);
    localparam kernel_t INV_Q_W2  = gen_inv_kernel(2);
    localparam kernel_t INV_Q_W4  = gen_inv_kernel(4);
    localparam kernel_t INV_Q_W8  = gen_inv_kernel(8);
    localparam kernel_t INV_Q_W16 = gen_inv_kernel(16);
    localparam kernel_t INV_Q_W32 = gen_inv_kernel(32);
    localparam kernel_t INV_Q_W64 = gen_inv_kernel(64);

    function automatic kernel_t select_kernel(input int w);
        case (w)
            1:       return INV_Q_W1;
            2:       return INV_Q_W2;
            4:       return INV_Q_W4;
            8:       return INV_Q_W8;
            16:      return INV_Q_W16;
            32:      return INV_Q_W32;
            default: return INV_Q_W64;
        endcase
    endfunction

endpackage

// File: rtl/col_parity_solve.sv
// col_parity_solve: combinational cyclic convolution of the encoded parity plane with the inverse
// kernel, yielding the original column parities P[.][z] for one slice index z.
module col_parity_solve
    import matrix_codec_pkg::*;
#(
    parameter int LANE_W = 64,
    parameter int ZW     = 6
) (
    input  logic [COLS-1:0][LANE_W-1:0] pp_plane,
    input  logic [ZW-1:0]               z,
    input  logic [COLS-1:0][LANE_W-1:0] kernel,
    output logic [COLS-1:0]             p_col
);

    // Z indices wrap for free because LANE_W is a power of two and z is exactly ZW bits wide.
    always_comb begin
        p_col = '0;
        for (int x = 0; x < COLS; x++) begin
            for (int a = 0; a < COLS; a++) begin
                for (int b = 0; b < LANE_W; b++) begin
                    p_col[x] = p_col[x] ^ (kernel[a][b] & pp_plane[(x + COLS - a) % COLS][z - ZW'(b)]);
                end
            end
        end
    end

endmodule

// File: rtl/col_parity_decoder.sv
// col_parity_decoder: loads an encoded 5x5xLANE_W frame, solves the original column parities, emits A.
// Define COL_PARITY_SELFCHECK_EN to add a re-encode check pass that drives the sticky err flag.
module col_parity_decoder
    import matrix_codec_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SLICE_BITS-1:0] in_slice,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SLICE_BITS-1:0] out_slice,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err
);

    localparam int      ZW          = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam kernel_t KERNEL_FULL = select_kernel(LANE_W);

    state_t                      state;
    state_t                      state_next;
    logic [ZW-1:0]               cnt;
    logic [ZW-1:0]               cnt_next;
    logic [ZW-1:0]               zm1;
    logic                        cnt_last;
    logic                        load_out;
    logic [SLICE_BITS-1:0]       buffer [LANE_W];
    logic [COLS-1:0][LANE_W-1:0] pp_plane;
    logic [COLS-1:0][LANE_W-1:0] p_plane;
    logic [COLS-1:0][LANE_W-1:0] kernel;
    logic [COLS-1:0]             in_par;
    logic [COLS-1:0]             solve_col;
    logic [SLICE_BITS-1:0]       decoded;

    always_comb begin
        for (int x = 0; x < COLS; x++) begin
            kernel[x] = KERNEL_FULL[x][LANE_W-1:0];
        end
    end

    assign cnt_last = (cnt == ZW'(LANE_W - 1));
    assign cnt_next = cnt_last ? '0 : cnt + 1'b1;
    assign zm1      = (cnt == '0) ? ZW'(LANE_W - 1) : cnt - 1'b1;
    assign in_par   = col_parity(in_slice);
    assign load_out = (state == EMIT) && (!out_valid || (out_ready && !out_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt_last) begin
                    state_next = SOLVE;
                end
            end
            SOLVE: begin
                busy = 1'b1;
                if (cnt_last) begin
`ifdef COL_PARITY_SELFCHECK_EN
                    state_next = CHECK;
`else
                    state_next = EMIT;
`endif
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (cnt_last) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                busy = 1'b1;
                if (out_valid && out_ready && out_last) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // The slice counter is shared by all phases and wraps to 0 at the end of each one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_slice <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt_next;
                    end
                end
                SOLVE, CHECK: cnt <= cnt_next;
                EMIT: begin
                    if (load_out) begin
                        out_slice <= decoded;
                        out_last  <= cnt_last;
                        out_valid <= 1'b1;
                        cnt       <= cnt_next;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            buffer[cnt] <= in_slice;
            for (int x = 0; x < COLS; x++) begin
                pp_plane[x][cnt] <= in_par[x];
            end
        end
        if (state == SOLVE) begin
            for (int x = 0; x < COLS; x++) begin
                p_plane[x][cnt] <= solve_col[x];
            end
        end
    end

    col_parity_solve #(
        .LANE_W (LANE_W),
        .ZW     (ZW)
    ) u_solve (
        .pp_plane (pp_plane),
        .z        (cnt),
        .kernel   (kernel),
        .p_col    (solve_col)
    );

    always_comb begin
        decoded = buffer[cnt];
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                decoded[x + COLS * y] = buffer[cnt][x + COLS * y]
                                      ^ p_plane[(x + COLS - 1) % COLS][cnt]
                                      ^ p_plane[(x + 1) % COLS][zm1];
            end
        end
    end

`ifdef COL_PARITY_SELFCHECK_EN
    logic [COLS-1:0] recheck;
    logic [COLS-1:0] pp_col;

    // Re-encoding needs P[x+1][z-1], so it runs only after every P column exists.
    always_comb begin
        recheck = '0;
        pp_col  = '0;
        for (int x = 0; x < COLS; x++) begin
            recheck[x] = p_plane[x][cnt] ^ p_plane[(x + COLS - 1) % COLS][cnt] ^ p_plane[(x + 1) % COLS][zm1];
            pp_col[x]  = pp_plane[x][cnt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == CHECK && recheck != pp_col) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
